// File: rtl/bcd_chain_pkg.sv
// Shared types and constants for the BCD chain run controller.
// Optional feature macro: BCD_CHAIN_AUTORELOAD_EN (see bcd_chain_ctrl).
package bcd_chain_pkg;

    typedef enum logic [2:0] {
        ST_CLR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Number of cycles the chain is held in clear.
    localparam int CLR_CYCLES = 2;
    localparam int CLR_CNT_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-enable prescaler: one tick every PRESCALE enabled cycles; holds its
// position while disabled and returns to zero on 'zero'.
module tick_prescaler #(
    parameter int PRESCALE = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic zero,
    output logic tick
);

    localparam int               CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_d = cnt_q;
        if (zero) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Run controller for a cascade of BCD digit counters: paces, clears and stops
// the chain at a programmable limit. Macro BCD_CHAIN_AUTORELOAD_EN restarts on match.
module bcd_chain_ctrl
    import bcd_chain_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic [4*DIGITS-1:0]   limit,
    input  logic [4*DIGITS-1:0]   count,
    input  logic                  chain_eu,
    output logic                  chain_ei,
    output logic                  chain_clr_,
    output logic                  running,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(CLR_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CLR_CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
`ifdef BCD_CHAIN_AUTORELOAD_EN
    logic                   reload_q, reload_d;
`endif

    logic limit_valid;
    logic match;
    logic tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .en    (state_q == ST_RUN),
        .zero  (state_q == ST_CLR),
        .tick  (tick)
    );

    // A limit holding any non-decimal digit can never be displayed, so it never matches.
    always_comb begin
        limit_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(limit[4*i +: 4])) begin
                limit_valid = 1'b0;
            end
        end
    end

    assign match    = limit_valid && (count == limit);
    assign chain_ei = tick && !match;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
`ifdef BCD_CHAIN_AUTORELOAD_EN
        reload_d  = reload_q;
`endif

        case (state_q)
            ST_CLR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
`ifdef BCD_CHAIN_AUTORELOAD_EN
                    state_d  = reload_q ? ST_RUN : ST_IDLE;
                    reload_d = 1'b0;
`else
                    state_d  = ST_IDLE;
`endif
                end
            end
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (match) begin
`ifdef BCD_CHAIN_AUTORELOAD_EN
                    state_d  = ST_CLR;
                    reload_d = 1'b1;
`else
                    state_d  = ST_DONE;
`endif
                end
            end
            ST_PAUSE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase

        if (clear) begin
            state_d   = ST_CLR;
            clr_cnt_d = '0;
`ifdef BCD_CHAIN_AUTORELOAD_EN
            reload_d  = 1'b0;
`endif
        end

        running_d = (state_d == ST_RUN);
`ifdef BCD_CHAIN_AUTORELOAD_EN
        // Only a match-driven entry into clear arms the reload, so this is the done pulse.
        done_d    = (state_q == ST_RUN) && (state_d == ST_CLR) && reload_d;
`else
        done_d    = (state_d == ST_DONE);
`endif

        overflow_d = overflow_q;
        if (state_q == ST_CLR) begin
            overflow_d = 1'b0;
        end else if (chain_ei && chain_eu) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLR;
            clr_cnt_q  <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            running_q  <= running_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef BCD_CHAIN_AUTORELOAD_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign chain_clr_ = (state_q != ST_CLR);
    assign running    = running_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/bcd_chain_ctrl.md
# bcd_chain_ctrl

Run controller for a cascade of decimal (BCD) digit counters chained through enable-in/enable-out. It paces the chain with a prescaled count enable, supports start/stop/clear commands, and halts the chain when the displayed count equals a programmable BCD limit. It sits between the user command logic and the digit chain, and it is the only driver of the chain's enable and clear.

## Interface
- DIGITS, 4: number of BCD digits in the chain (≥1).
- PRESCALE, 10: clock cycles per count tick (≥1).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle command: begin or resume counting.
- stop  in  1  one-cycle command: pause.
- clear  in  1  one-cycle command: zero the chain and return to idle.
- limit  in  4*DIGITS  BCD terminal value; digit i is bits 4i+3..4i.
- count  in  4*DIGITS  current chain value (registered chain outputs).
- chain_eu  in  1  enable-out of the most significant digit.
- chain_ei  out  1  enable-in to the least significant digit.
- chain_clr_  out  1  active-low clear to the chain's reset_ inputs.
- running  out  1  high in RUN.
- done  out  1  limit reached.
- overflow  out  1  sticky: chain wrapped past all nines.

## Operation
- States: CLR, IDLE, RUN, PAUSE, DONE.
- CLR: chain_clr_=0, prescaler=0, overflow cleared; held exactly 2 cycles, then IDLE.
- IDLE: start → RUN; stop ignored.
- RUN: prescaler counts 0..PRESCALE-1; tick when it equals PRESCALE-1, then it wraps to 0. chain_ei = tick & ~match, where match = (count == limit).
- RUN with match → DONE on the next edge. Start with count already equal to limit → RUN for one cycle with no tick, then DONE.
- RUN: stop → PAUSE. The prescaler holds its value. PAUSE: start → RUN and resumes from the held prescaler value.
- DONE: start and stop are ignored; only clear leaves DONE.
- Command priority: clear > stop > start. clear from any state → CLR.
- Limit digits >9 never match. The chain counts indefinitely and wraps.
- chain_ei & chain_eu in the same cycle → overflow=1 from the next edge until CLR.

## Timing
- Reset values: state CLR, chain_clr_=0, chain_ei=0, running=0, done=0, overflow=0, prescaler=0.
- Reset deasserted → chain_clr_ stays low for 2 more rising edges, then goes high in IDLE.
- Start sampled at edge k → running=1 after k. The first chain_ei is high in cycle k+PRESCALE. Subsequent chain_ei pulses are one cycle wide, every PRESCALE cycles.
- The chain updates count on the edge closing an ei-high cycle. match is combinational on count, so ei never overshoots the limit.
- done and running are registered decodes of the state: done=1 from the edge after match is seen in RUN.
- PRESCALE=1: chain_ei high every RUN cycle until match.

## Configuration
- BCD_CHAIN_AUTORELOAD_EN defined:
  - match in RUN → CLR → RUN (the 2-cycle clear is followed directly by RUN, not IDLE).
  - done is a one-cycle pulse in the cycle entering CLR.
  - The DONE state is unreachable.
- BCD_CHAIN_AUTORELOAD_EN undefined: behaviour as above; DONE is terminal until clear.

## Structure
- Package bcd_chain_pkg holds:
  - the state enum;
  - CLR_CYCLES = 2;
  - a BCD digit-valid helper function.
- Sub-module tick_prescaler (parameter PRESCALE; inputs clock, reset, en, zero; output tick) implements the prescaler, including hold-while-disabled.
- The FSM, match comparator and overflow flag stay in bcd_chain_ctrl.

## Test plan
The bench uses DIGITS=2, PRESCALE=4 and a behavioural 2-digit chain model.
- Reset pulse:
  - During reset: chain_clr_=0, running=0, done=0, overflow=0, chain_ei=0.
  - After release: chain_clr_=1 exactly after 2 edges.
- Limit 8'h12, start:
  - chain_ei is high every 4th cycle.
  - After 12 pulses, count=8'h12, done=1, running=0, and chain_ei stays 0 for 50 cycles.
- Pause/resume:
  - stop 2 cycles after the 3rd tick → no chain_ei for 20 cycles.
  - start → the next chain_ei arrives 2 cycles after resume.
- Command priority:
  - clear and start in the same cycle during RUN → CLR, then IDLE, with running=0.
  - stop and start in the same cycle → PAUSE.
- Limit 8'hA0 (invalid):
  - After 100 ticks the count wraps 99→00 with chain_eu & chain_ei, and overflow=1.
  - Counting continues; clear resets overflow to 0.
- BCD_CHAIN_AUTORELOAD_EN, limit 8'h03:
  - done pulses one cycle every 3 ticks plus 2 clear cycles.
  - chain_clr_ pulses low for 2 cycles each time, and running returns to 1.
